// File: rtl/sparse_tile_encoder.sv
// Dense-to-sparse tile encoder: row-major bitmap plus packed nonzero buffer, one tile held at a time.
// Optional magnitude-threshold zero test is enabled with the SPARSE_ENC_THRESH_EN macro.
module sparse_tile_encoder #(
  parameter int ROW_SIZE       = 4,
  parameter int COL_SIZE       = 8,
  parameter int LOG2_ROW_SIZE  = 2,
  parameter int DATA_TYPE      = 32,
  parameter int BUFF_SIZE      = 32,
  parameter int LOG2_BUFF_SIZE = 5,
  parameter int CNT_W          = 6
) (
  input  logic                            clk,
  input  logic                            rst,
`ifdef SPARSE_ENC_THRESH_EN
  input  logic [DATA_TYPE-1:0]            zero_thresh,
`endif
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [COL_SIZE*DATA_TYPE-1:0]   in_row,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ROW_SIZE*COL_SIZE-1:0]    out_bit_map,
  output logic [BUFF_SIZE*DATA_TYPE-1:0]  out_nonzero_ele,
  output logic [CNT_W-1:0]                out_nnz,
  output logic                            out_overflow
);

  // One extra bit so slot indices past the buffer end never wrap back into it
  localparam int SLOT_W = CNT_W + 1;
  localparam logic [SLOT_W-1:0]        BUFF_LIM = SLOT_W'(BUFF_SIZE);
  localparam logic [LOG2_ROW_SIZE-1:0] LAST_ROW = LOG2_ROW_SIZE'(ROW_SIZE - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                        state;
  logic [LOG2_ROW_SIZE-1:0]      row_cnt;
  logic [CNT_W-1:0]              nnz;
  logic [ROW_SIZE*COL_SIZE-1:0]  bit_map;
  logic [DATA_TYPE-1:0]          buff [BUFF_SIZE];
  logic                          overflow;

  logic [DATA_TYPE-1:0]          ele [COL_SIZE];
  logic [COL_SIZE-1:0]           mask;
  logic [SLOT_W-1:0]             slot [COL_SIZE];
  logic [SLOT_W-1:0]             nnz_next;

  generate
    for (genvar gi = 0; gi < COL_SIZE; gi++) begin : g_col
      assign ele[gi] = in_row[gi*DATA_TYPE +: DATA_TYPE];
`ifdef SPARSE_ENC_THRESH_EN
      // Two's-complement magnitude; the most negative value saturates to the largest positive
      logic [DATA_TYPE-1:0] mag;
      always_comb begin
        mag = ele[gi];
        if (ele[gi] == {1'b1, {(DATA_TYPE-1){1'b0}}})
          mag = {1'b0, {(DATA_TYPE-1){1'b1}}};
        else if (ele[gi][DATA_TYPE-1])
          mag = (~ele[gi]) + {{(DATA_TYPE-1){1'b0}}, 1'b1};
      end
      assign mask[gi] = (mag > zero_thresh);
`else
      assign mask[gi] = |ele[gi];
`endif
    end
  endgenerate

  // Running prefix count gives each nonzero its destination slot within the tile
  always_comb begin
    slot[0] = SLOT_W'(nnz);
    for (int c = 1; c < COL_SIZE; c++)
      slot[c] = slot[c-1] + SLOT_W'(mask[c-1]);
    nnz_next = slot[COL_SIZE-1] + SLOT_W'(mask[COL_SIZE-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      row_cnt   <= '0;
      nnz       <= '0;
      bit_map   <= '0;
      overflow  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      for (int k = 0; k < BUFF_SIZE; k++)
        buff[k] <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            bit_map[row_cnt*COL_SIZE +: COL_SIZE] <= mask;
            for (int c = 0; c < COL_SIZE; c++)
              if (mask[c] && (slot[c] < BUFF_LIM))
                buff[slot[c][LOG2_BUFF_SIZE-1:0]] <= ele[c];
            nnz      <= nnz_next[CNT_W-1:0];
            overflow <= (nnz_next > BUFF_LIM);
            if (row_cnt == LAST_ROW) begin
              row_cnt   <= '0;
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              row_cnt <= row_cnt + LOG2_ROW_SIZE'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= FILL;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            nnz       <= '0;
            bit_map   <= '0;
            overflow  <= 1'b0;
            for (int k = 0; k < BUFF_SIZE; k++)
              buff[k] <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < BUFF_SIZE; gi++) begin : g_out
      assign out_nonzero_ele[gi*DATA_TYPE +: DATA_TYPE] = buff[gi];
    end
  endgenerate

  assign out_bit_map  = bit_map;
  assign out_nnz      = nnz;
  assign out_overflow = overflow;

endmodule

// File: tb/tb_sparse_tile_encoder.sv
// Scoreboard bench for sparse_tile_encoder: a 32-slot and a 16-slot instance share one stimulus stream.
// Define SPARSE_ENC_THRESH_EN to also exercise the magnitude-threshold zero test.
module tb_sparse_tile_encoder;

  localparam int R  = 4;
  localparam int C  = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            in_valid;
  logic            out_ready;
  logic [C*DW-1:0] in_row;
`ifdef SPARSE_ENC_THRESH_EN
  logic [DW-1:0]   zero_thresh;
`endif

  logic          in_ready_a, out_valid_a, out_overflow_a;
  logic [31:0]   out_bit_map_a;
  logic [1023:0] out_nonzero_ele_a;
  logic [5:0]    out_nnz_a;

  logic          in_ready_b, out_valid_b, out_overflow_b;
  logic [31:0]   out_bit_map_b;
  logic [511:0]  out_nonzero_ele_b;
  logic [5:0]    out_nnz_b;

  sparse_tile_encoder dut_a (
    .clk(clk), .rst(rst),
`ifdef SPARSE_ENC_THRESH_EN
    .zero_thresh(zero_thresh),
`endif
    .in_valid(in_valid), .in_ready(in_ready_a), .in_row(in_row),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_bit_map(out_bit_map_a),
    .out_nonzero_ele(out_nonzero_ele_a), .out_nnz(out_nnz_a), .out_overflow(out_overflow_a)
  );

  sparse_tile_encoder #(.BUFF_SIZE(16), .LOG2_BUFF_SIZE(4)) dut_b (
    .clk(clk), .rst(rst),
`ifdef SPARSE_ENC_THRESH_EN
    .zero_thresh(zero_thresh),
`endif
    .in_valid(in_valid), .in_ready(in_ready_b), .in_row(in_row),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_bit_map(out_bit_map_b),
    .out_nonzero_ele(out_nonzero_ele_b), .out_nnz(out_nnz_b), .out_overflow(out_overflow_b)
  );

  typedef struct packed {
    logic [31:0]   bm;
    logic [5:0]    nnz;
    logic          ovf;
    logic [1023:0] buff;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] tile [32];
  int          checks = 0;
  int          errors = 0;

  function automatic logic keep(input logic [31:0] x);
`ifdef SPARSE_ENC_THRESH_EN
    logic signed [31:0] v;
    logic [31:0] mag;
    v = x;
    if (x == 32'h8000_0000) mag = 32'h7fff_ffff;
    else if (v < 0)         mag = -v;
    else                    mag = v;
    return mag > zero_thresh;
`else
    return x != 32'd0;
`endif
  endfunction

  // Reference encoding of the current tile for a buffer of bsz slots
  function automatic exp_t model(input int bsz);
    exp_t e;
    int k;
    e = '0;
    k = 0;
    for (int i = 0; i < 32; i++) begin
      if (keep(tile[i])) begin
        e.bm[i] = 1'b1;
        if (k < bsz) e.buff[k*32 +: 32] = tile[i];
        k++;
      end
    end
    e.nnz = 6'(k);
    e.ovf = (k > bsz);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_buf(input string name, input logic [1023:0] act, input logic [1023:0] exp,
                         input int nslots);
    int bad;
    bad = -1;
    for (int k = nslots - 1; k >= 0; k--)
      if (act[k*32 +: 32] !== exp[k*32 +: 32]) bad = k;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s slot %0d actual=%0h required=%0h", name, bad,
               act[bad*32 +: 32], exp[bad*32 +: 32]);
    end
  endtask

  // Monitor: one comparison set per tile taken by the consumer
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_ready) begin
      if (out_valid_a) begin
        if (q_a.size() == 0) chk("unexpected_tile_a", 64'd1, 64'd0);
        else begin
          e = q_a.pop_front();
          $display("tile a: nnz=%0d bitmap=%h ovf=%0d", out_nnz_a, out_bit_map_a, out_overflow_a);
          chk("bitmap_a", 64'(out_bit_map_a), 64'(e.bm));
          chk("nnz_a", 64'(out_nnz_a), 64'(e.nnz));
          chk("overflow_a", 64'(out_overflow_a), 64'(e.ovf));
          chk_buf("buffer_a", out_nonzero_ele_a, e.buff, 32);
        end
      end
      if (out_valid_b) begin
        if (q_b.size() == 0) chk("unexpected_tile_b", 64'd1, 64'd0);
        else begin
          e = q_b.pop_front();
          $display("tile b: nnz=%0d bitmap=%h ovf=%0d", out_nnz_b, out_bit_map_b, out_overflow_b);
          chk("bitmap_b", 64'(out_bit_map_b), 64'(e.bm));
          chk("nnz_b", 64'(out_nnz_b), 64'(e.nnz));
          chk("overflow_b", 64'(out_overflow_b), 64'(e.ovf));
          chk_buf("buffer_b", {512'd0, out_nonzero_ele_b}, e.buff, 16);
        end
      end
    end
  end

  task automatic load_row(input int r);
    for (int c = 0; c < C; c++) in_row[c*DW +: DW] = tile[r*C + c];
  endtask

  // Present row r and return #1 after the edge that accepts it
  task automatic send_row(input int r);
    int n;
    load_row(r);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_tile;
    q_a.push_back(model(32));
    q_b.push_back(model(16));
    for (int r = 0; r < R; r++) begin
      send_row(r);
      if (r < R - 1) chk("valid_early", 64'(out_valid_a), 64'd0);
    end
    chk("latency_valid", 64'(out_valid_a), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] snap_bm;
    logic [5:0]  snap_nnz;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_row = '0;
`ifdef SPARSE_ENC_THRESH_EN
    zero_thresh = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready_a), 64'd1);
    chk("reset_out_valid", 64'(out_valid_a), 64'd0);
    chk("reset_nnz", 64'(out_nnz_a), 64'd0);
    chk("reset_bitmap", 64'(out_bit_map_a), 64'd0);
    chk("reset_overflow", 64'(out_overflow_a), 64'd0);
    @(posedge clk);
    #1;

    // Identity-like tile: element (r,r) = r+1
    for (int i = 0; i < 32; i++) tile[i] = ((i / C) == (i % C)) ? 32'((i / C) + 1) : 32'd0;
    send_tile();
    drain();

    // Fully dense 1..32: exact fit for 32 slots, overflow for 16 slots
    for (int i = 0; i < 32; i++) tile[i] = 32'(i + 1);
    send_tile();
    drain();

    // All-zero tile
    for (int i = 0; i < 32; i++) tile[i] = 32'd0;
    send_tile();
    drain();

    // Consumer stall while the producer offers the next tile's first row
    for (int i = 0; i < 32; i++) tile[i] = (i % 3 == 0) ? 32'(100 + i) : 32'd0;
    out_ready = 1'b0;
    send_tile();
    snap_bm  = out_bit_map_a;
    snap_nnz = out_nnz_a;
    for (int i = 0; i < 32; i++) tile[i] = (i % 2 == 1) ? 32'(i * 7 + 3) : 32'd0;
    load_row(0);
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready_a), 64'd0);
      chk("stall_out_valid", 64'(out_valid_a), 64'd1);
      chk("stall_bitmap", 64'(out_bit_map_a), 64'(snap_bm));
      chk("stall_nnz", 64'(out_nnz_a), 64'(snap_nnz));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_out_valid", 64'(out_valid_a), 64'd0);
    chk("release_in_ready", 64'(in_ready_a), 64'd1);
    chk("release_nnz_clear", 64'(out_nnz_a), 64'd0);
    chk("release_bitmap_clear", 64'(out_bit_map_a), 64'd0);
    send_tile();
    drain();

    // Reset after two accepted rows must leave no residue
    for (int i = 0; i < 32; i++) tile[i] = 32'hffff_0000 + 32'(i);
    send_row(0);
    send_row(1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midtile_rst_valid", 64'(out_valid_a), 64'd0);
    chk("midtile_rst_in_ready", 64'(in_ready_a), 64'd1);
    chk("midtile_rst_nnz", 64'(out_nnz_a), 64'd0);
    for (int i = 0; i < 32; i++) tile[i] = ($urandom_range(0, 2) == 0) ? ($urandom | 32'd1) : 32'd0;
    send_tile();
    drain();

`ifdef SPARSE_ENC_THRESH_EN
    zero_thresh = 32'd5;
    for (int i = 0; i < 32; i++) tile[i] = 32'd0;
    tile[0] = 32'd3;
    tile[1] = 32'hffff_fff9;
    tile[2] = 32'd5;
    tile[3] = 32'd6;
    send_tile();
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
